maze_game_core: RTL and testbench
=================================

Name: maze_game_core

Overview:
Parametrised game engine for the VGA maze collector: player position, N collectibles, N trap rectangles, a lives counter and the game state machine. The engine is display-independent. The top level feeds it a divided move tick, debounced buttons and start/ack switches. It drives the renderer and the SSD/LED logic from registered outputs. It generalises the fixed four-flag/four-trap game with parametrised counts, multiple lives, respawn with invulnerability, and a score output.

Parameters:
CW, 10, coordinate width (bits)
N_ITEMS, 4, number of collectibles
N_TRAPS, 4, number of trap rectangles
STEP, 4, pixels moved per move tick
HALF, 10, player half-size (player box = centre ±HALF)
ITEM_TOL, 6, collect radius: |dx|<=ITEM_TOL and |dy|<=ITEM_TOL
LIVES, 3, lives at game start (>=1)
HIT_TICKS, 8, invulnerable move ticks after a trap hit
X_MIN, 60 / X_MAX, 560 / Y_MIN, 60 / Y_MAX, 460, playfield clamp for the player centre
SPAWN_X, 320 / SPAWN_Y, 70, start and respawn position

Ports:
clk  in  1  system clock
reset  in  1  synchronous, active-high reset
move_tick  in  1  one-cycle game-rate enable
btn_up, btn_down, btn_left, btn_right  in  1 each  direction requests, level
start  in  1  level; leaves IDLE
ack  in  1  level; leaves LOSE/WIN
item_x, item_y  in  N_ITEMS*CW each  item centres, item i at [i*CW +: CW]
trap_x0, trap_x1, trap_y0, trap_y1  in  N_TRAPS*CW each  inclusive trap rectangles
player_x, player_y  out  CW each  player centre
collected  out  N_ITEMS  bit i set once item i is taken
score  out  $clog2(N_ITEMS+1)  popcount of collected
lives  out  $clog2(LIVES+1)  remaining lives
state  out  3  0 IDLE, 1 PLAY, 2 HIT, 3 LOSE, 4 WIN
time_left  out  16  remaining ticks (see Optional Feature)

Behaviour:
- Clock and reset: one clock (clk). reset is synchronous and active-high and overrides everything.
- Reset values: state=IDLE, player=(SPAWN_X,SPAWN_Y), collected=0, score=0, lives=LIVES, hit counter=0, time_left=0. All outputs are registered.
- IDLE: holds the reset values every cycle. When start=1, go to PLAY on the next clk; no tick is needed.
- PLAY movement: happens only on cycles with move_tick=1.
  - up&down both pressed, or neither: no Y move. Same rule for left/right on X.
  - Up subtracts STEP, down adds STEP; same for left/right. Diagonal moves are allowed.
  - The result is saturated to [X_MIN,X_MAX] / [Y_MIN,Y_MAX]. Arithmetic is done in CW+1 bits so there is no wrap-around below 0.
- Collision: evaluated every cycle in PLAY against the registered position, so it takes effect 1 cycle after the move.
  - Item i is collected when both |dx| and |dy| are <= ITEM_TOL. collected[i] is sticky. score updates in the same cycle as collected.
  - A trap is hit when the player box [x±HALF, y±HALF] overlaps any trap rectangle (inclusive bounds).
- Precedence in one cycle:
  - If the final item is collected in the same cycle as a trap hit, go to WIN and lives are unchanged.
  - Otherwise, a trap hit with lives==1 sets lives=0 and goes to LOSE.
  - Otherwise, a trap hit decrements lives, moves the player to spawn and goes to HIT with hit counter=HIT_TICKS.
- HIT: no movement and no trap checks; collected is frozen. The counter decrements on each move_tick. When the counter is 0, return to PLAY. Items are not re-spawned.
- LOSE/WIN: all outputs are frozen. When ack=1, go to IDLE on the next clk, and IDLE reloads the reset values. If start and ack are both high in LOSE/WIN, go only to IDLE; the game re-enters PLAY one cycle later if start is still high.
- A trap overlapping the spawn point causes repeated hits after HIT. This is legal; the bench checks it drains lives to LOSE.
- N_ITEMS=0 is illegal; the design gives an elaboration error.

Optional Feature:
MAZE_TIMER_EN.
- Defined: adds parameter TIME_LIMIT (default 1000).
  - Entering PLAY from IDLE loads time_left=TIME_LIMIT.
  - Each move_tick in PLAY or HIT decrements time_left.
  - When time_left reaches 0 in PLAY or HIT, go to LOSE. A WIN in the same cycle takes precedence.
- Undefined: time_left is tied to 0 and there is no timeout.

Test Plan:
- Reset then start=1 -> state=1 the next cycle. Player (320,70), lives=3, score=0.
- Hold btn_right for 100 ticks from x=320 -> x increases 4 per tick, saturates at 560. Hold up+down -> y unchanged.
- Item 0 at (324,70), press right 1 tick -> the cycle after the tick, collected=0001 and score=1. Moving away keeps the bit set.
- Trap (200..260, 50..70), player walks left from 320 -> hit when x-10<=260. lives=2, player=(320,70), state=2 for 8 ticks, then state=1.
- Three hits -> lives 3→2→1→0, state=3. ack=1 -> state=0 with reset values restored.
- Collect all 4 items with the final one coinciding with a trap overlap -> state=4, lives unchanged. With MAZE_TIMER_EN and TIME_LIMIT=5, idle for 5 ticks in PLAY -> state=3, time_left=0.

Source files
------------

// File: rtl/maze_game_core.sv
// maze_game_core: display-independent game engine for the VGA maze collector.
// Tracks the player centre, sticky item collection with a score, a lives
// counter with a post-hit invulnerability window, and the
// IDLE/PLAY/HIT/LOSE/WIN state machine. All outputs come straight from registers.
// Build macro MAZE_TIMER_EN: when defined, adds parameter TIME_LIMIT and a
// countdown that ends the game with LOSE when it expires. When undefined,
// time_left is held at zero and the game has no timeout.

module maze_game_core #(
    parameter int CW        = 10,
    parameter int N_ITEMS   = 4,
    parameter int N_TRAPS   = 4,
    parameter int STEP      = 4,
    parameter int HALF      = 10,
    parameter int ITEM_TOL  = 6,
    parameter int LIVES     = 3,
    parameter int HIT_TICKS = 8,
    parameter int X_MIN     = 60,
    parameter int X_MAX     = 560,
    parameter int Y_MIN     = 60,
    parameter int Y_MAX     = 460,
    parameter int SPAWN_X   = 320,
    parameter int SPAWN_Y   = 70
`ifdef MAZE_TIMER_EN
    ,
    parameter int TIME_LIMIT = 1000
`endif
) (
    input  logic                           clk,
    input  logic                           reset,
    input  logic                           move_tick,
    input  logic                           btn_up,
    input  logic                           btn_down,
    input  logic                           btn_left,
    input  logic                           btn_right,
    input  logic                           start,
    input  logic                           ack,
    input  logic [N_ITEMS*CW-1:0]          item_x,
    input  logic [N_ITEMS*CW-1:0]          item_y,
    input  logic [N_TRAPS*CW-1:0]          trap_x0,
    input  logic [N_TRAPS*CW-1:0]          trap_x1,
    input  logic [N_TRAPS*CW-1:0]          trap_y0,
    input  logic [N_TRAPS*CW-1:0]          trap_y1,
    output logic [CW-1:0]                  player_x,
    output logic [CW-1:0]                  player_y,
    output logic [N_ITEMS-1:0]             collected,
    output logic [$clog2(N_ITEMS+1)-1:0]   score,
    output logic [$clog2(LIVES+1)-1:0]     lives,
    output logic [2:0]                     state,
    output logic [15:0]                    time_left
);

    localparam int SW = $clog2(N_ITEMS + 1);
    localparam int LW = $clog2(LIVES + 1);
    localparam int HW = $clog2(HIT_TICKS + 2);
    localparam int EW = CW + 1;

    localparam logic [CW-1:0] X_MIN_C   = CW'(X_MIN);
    localparam logic [CW-1:0] X_MAX_C   = CW'(X_MAX);
    localparam logic [CW-1:0] Y_MIN_C   = CW'(Y_MIN);
    localparam logic [CW-1:0] Y_MAX_C   = CW'(Y_MAX);
    localparam logic [CW-1:0] SPAWN_X_C = CW'(SPAWN_X);
    localparam logic [CW-1:0] SPAWN_Y_C = CW'(SPAWN_Y);
    localparam logic [CW-1:0] TOL_C     = CW'(ITEM_TOL);
    localparam logic [EW-1:0] STEP_E    = EW'(STEP);
    localparam logic [EW-1:0] HALF_E    = EW'(HALF);
    localparam logic [LW-1:0] LIVES_C   = LW'(LIVES);
    localparam logic [LW-1:0] LIFE_ONE  = LW'(1'b1);
    localparam logic [HW-1:0] HIT_C     = HW'(HIT_TICKS);
    localparam logic [HW-1:0] HIT_ONE   = HW'(1'b1);
`ifdef MAZE_TIMER_EN
    localparam logic [15:0]   TIME_LOAD = 16'(TIME_LIMIT);
`else
    localparam logic [15:0]   TIME_LOAD = 16'd0;
`endif

    // Reject configurations the engine cannot represent.
    generate
        if (N_ITEMS < 1) begin : g_bad_n_items
            $error("maze_game_core: N_ITEMS must be at least 1");
        end
        if (LIVES < 1) begin : g_bad_lives
            $error("maze_game_core: LIVES must be at least 1");
        end
    endgenerate

    typedef enum logic [2:0] {
        ST_IDLE = 3'd0,
        ST_PLAY = 3'd1,
        ST_HIT  = 3'd2,
        ST_LOSE = 3'd3,
        ST_WIN  = 3'd4
    } state_t;

    state_t               state_r;
    logic [CW-1:0]        x_r;
    logic [CW-1:0]        y_r;
    logic [N_ITEMS-1:0]   coll_r;
    logic [SW-1:0]        score_r;
    logic [LW-1:0]        lives_r;
    logic [HW-1:0]        hit_r;
    logic [15:0]          time_r;

    logic [CW-1:0]        move_x_s;
    logic [CW-1:0]        move_y_s;
    logic [N_ITEMS-1:0]   item_hit_s;
    logic [N_ITEMS-1:0]   coll_next_s;
    logic                 all_items_s;
    logic                 trap_hit_s;
    logic                 timeout_s;
    logic [15:0]          time_next_s;
    logic                 reload_s;
    logic                 leave_idle_s;

    function automatic logic [CW-1:0] abs_diff(input logic [CW-1:0] a, input logic [CW-1:0] b);
        return (a >= b) ? (a - b) : (b - a);
    endfunction

    // One axis of movement: opposing buttons cancel, the sum is formed one bit
    // wider so a decrement can never wrap, then clamped to the playfield.
    function automatic logic [CW-1:0] step_axis(
        input logic [CW-1:0] pos,
        input logic          dec,
        input logic          inc,
        input logic [CW-1:0] lo,
        input logic [CW-1:0] hi
    );
        logic [EW-1:0] nxt;
        if (dec && !inc) begin
            nxt = ({1'b0, pos} >= STEP_E) ? ({1'b0, pos} - STEP_E) : {EW{1'b0}};
        end else if (inc && !dec) begin
            nxt = {1'b0, pos} + STEP_E;
        end else begin
            nxt = {1'b0, pos};
        end
        return (nxt < {1'b0, lo}) ? lo : ((nxt > {1'b0, hi}) ? hi : nxt[CW-1:0]);
    endfunction

    function automatic logic [SW-1:0] popcount(input logic [N_ITEMS-1:0] v);
        logic [SW-1:0] acc;
        acc = {SW{1'b0}};
        for (int i = 0; i < N_ITEMS; i++) begin
            acc = acc + SW'(v[i]);
        end
        return acc;
    endfunction

    // Candidate position for this move tick, taken from the button levels.
    always_comb begin
        move_x_s = step_axis(x_r, btn_left, btn_right, X_MIN_C, X_MAX_C);
        move_y_s = step_axis(y_r, btn_up, btn_down, Y_MIN_C, Y_MAX_C);
    end

    // Item and trap collision against the registered player position.
    always_comb begin
        item_hit_s = {N_ITEMS{1'b0}};
        trap_hit_s = 1'b0;
        for (int i = 0; i < N_ITEMS; i++) begin
            item_hit_s[i] = (abs_diff(x_r, item_x[i*CW +: CW]) <= TOL_C) &&
                            (abs_diff(y_r, item_y[i*CW +: CW]) <= TOL_C);
        end
        for (int t = 0; t < N_TRAPS; t++) begin
            trap_hit_s = trap_hit_s |
                (({1'b0, x_r} + HALF_E >= {1'b0, trap_x0[t*CW +: CW]}) &&
                 ({1'b0, x_r} <= {1'b0, trap_x1[t*CW +: CW]} + HALF_E) &&
                 ({1'b0, y_r} + HALF_E >= {1'b0, trap_y0[t*CW +: CW]}) &&
                 ({1'b0, y_r} <= {1'b0, trap_y1[t*CW +: CW]} + HALF_E));
        end
        coll_next_s = coll_r | item_hit_s;
        all_items_s = &coll_next_s;
    end

`ifdef MAZE_TIMER_EN
    // Countdown step; expiry is the tick that takes the count from 1 to 0.
    always_comb begin
        if (move_tick && (time_r != 16'd0)) begin
            time_next_s = time_r - 16'd1;
            timeout_s   = (time_r == 16'd1);
        end else begin
            time_next_s = time_r;
            timeout_s   = 1'b0;
        end
    end
`else
    assign time_next_s = 16'd0;
    assign timeout_s   = 1'b0;
`endif

    // Decide when the start-of-game values are (re)loaded: every IDLE cycle,
    // on ack from a finished game, and from any unused encoding.
    always_comb begin
        leave_idle_s = (state_r == ST_IDLE) && start;
        case (state_r)
            ST_IDLE:          reload_s = 1'b1;
            ST_PLAY, ST_HIT:  reload_s = 1'b0;
            ST_LOSE, ST_WIN:  reload_s = ack;
            default:          reload_s = 1'b1;
        endcase
    end

    // Game state machine and all registered outputs.
    always_ff @(posedge clk) begin
        if (reset) begin
            state_r <= ST_IDLE;
            x_r     <= SPAWN_X_C;
            y_r     <= SPAWN_Y_C;
            coll_r  <= {N_ITEMS{1'b0}};
            score_r <= {SW{1'b0}};
            lives_r <= LIVES_C;
            hit_r   <= {HW{1'b0}};
            time_r  <= 16'd0;
        end else if (reload_s) begin
            state_r <= leave_idle_s ? ST_PLAY : ST_IDLE;
            x_r     <= SPAWN_X_C;
            y_r     <= SPAWN_Y_C;
            coll_r  <= {N_ITEMS{1'b0}};
            score_r <= {SW{1'b0}};
            lives_r <= LIVES_C;
            hit_r   <= {HW{1'b0}};
            time_r  <= leave_idle_s ? TIME_LOAD : 16'd0;
        end else begin
            case (state_r)
                ST_PLAY: begin
                    coll_r  <= coll_next_s;
                    score_r <= popcount(coll_next_s);
                    time_r  <= time_next_s;
                    // Finishing the collection beats everything else; the
                    // player is left where the game ended.
                    if (all_items_s) begin
                        state_r <= ST_WIN;
                    end else if (timeout_s) begin
                        state_r <= ST_LOSE;
                    end else if (trap_hit_s) begin
                        if (lives_r <= LIFE_ONE) begin
                            lives_r <= {LW{1'b0}};
                            state_r <= ST_LOSE;
                        end else begin
                            lives_r <= lives_r - LIFE_ONE;
                            x_r     <= SPAWN_X_C;
                            y_r     <= SPAWN_Y_C;
                            hit_r   <= HIT_C;
                            state_r <= ST_HIT;
                        end
                    end else if (move_tick) begin
                        x_r <= move_x_s;
                        y_r <= move_y_s;
                    end
                end
                ST_HIT: begin
                    time_r <= time_next_s;
                    if (timeout_s) begin
                        state_r <= ST_LOSE;
                    end else if (hit_r == {HW{1'b0}}) begin
                        state_r <= ST_PLAY;
                    end else if (move_tick) begin
                        hit_r <= hit_r - HIT_ONE;
                    end
                end
                default: begin
                    // LOSE/WIN without ack: everything stays frozen.
                    state_r <= state_r;
                end
            endcase
        end
    end

    assign player_x  = x_r;
    assign player_y  = y_r;
    assign collected = coll_r;
    assign score     = score_r;
    assign lives     = lives_r;
    assign state     = state_r;
    assign time_left = time_r;

endmodule

// File: tb/tb_maze_game_core.sv
// Scoreboard bench for maze_game_core: a driver issues one input vector per
// cycle, steps an integer-level game model and queues the expected outputs;
// a monitor pops and compares every output after each clock edge.

module tb_maze_game_core;

    localparam int CW = 10, N_ITEMS = 4, N_TRAPS = 4, STEP = 4, HALF = 10;
    localparam int ITEM_TOL = 6, LIVES = 3, HIT_TICKS = 8;
    localparam int X_MIN = 60, X_MAX = 560, Y_MIN = 60, Y_MAX = 460;
    localparam int SPAWN_X = 320, SPAWN_Y = 70;
`ifdef MAZE_TIMER_EN
    localparam bit TIMER_ON   = 1'b1;
    localparam int TIME_LIMIT = 1000;
`else
    localparam bit TIMER_ON   = 1'b0;
    localparam int TIME_LIMIT = 0;
`endif
    localparam int SW = $clog2(N_ITEMS + 1);
    localparam int LW = $clog2(LIVES + 1);

    logic                  clk = 1'b0;
    logic                  reset = 1'b1;
    logic                  move_tick = 1'b0;
    logic                  btn_up = 1'b0, btn_down = 1'b0, btn_left = 1'b0, btn_right = 1'b0;
    logic                  start = 1'b0, ack = 1'b0;
    logic [N_ITEMS*CW-1:0] item_x = '0, item_y = '0;
    logic [N_TRAPS*CW-1:0] trap_x0 = '0, trap_x1 = '0, trap_y0 = '0, trap_y1 = '0;
    logic [CW-1:0]         player_x, player_y;
    logic [N_ITEMS-1:0]    collected;
    logic [SW-1:0]         score;
    logic [LW-1:0]         lives;
    logic [2:0]            state;
    logic [15:0]           time_left;

    always #5 clk = ~clk;

    maze_game_core #(
        .CW(CW), .N_ITEMS(N_ITEMS), .N_TRAPS(N_TRAPS), .STEP(STEP), .HALF(HALF),
        .ITEM_TOL(ITEM_TOL), .LIVES(LIVES), .HIT_TICKS(HIT_TICKS),
        .X_MIN(X_MIN), .X_MAX(X_MAX), .Y_MIN(Y_MIN), .Y_MAX(Y_MAX),
        .SPAWN_X(SPAWN_X), .SPAWN_Y(SPAWN_Y)
    ) dut (
        .clk(clk), .reset(reset), .move_tick(move_tick),
        .btn_up(btn_up), .btn_down(btn_down), .btn_left(btn_left), .btn_right(btn_right),
        .start(start), .ack(ack),
        .item_x(item_x), .item_y(item_y),
        .trap_x0(trap_x0), .trap_x1(trap_x1), .trap_y0(trap_y0), .trap_y1(trap_y1),
        .player_x(player_x), .player_y(player_y), .collected(collected),
        .score(score), .lives(lives), .state(state), .time_left(time_left)
    );

    typedef struct {
        int st; int x; int y; int coll; int score; int lives; int tl;
    } exp_t;

    exp_t sb_q[$];
    int   n_checks = 0;
    int   n_errors = 0;

    // Reference game state (states: 0 idle, 1 play, 2 hit, 3 lose, 4 win)
    int m_st, m_x, m_y, m_coll, m_lives, m_hit, m_tl;

    task automatic chk(input string name, input int act, input int exp);
        n_checks++;
        if (act != exp) begin
            n_errors++;
            $display("FAIL %s: got %0d, expected %0d (t=%0t)", name, act, exp, $time);
        end
    endtask

    function automatic int iabs(input int v);
        return (v < 0) ? -v : v;
    endfunction

    function automatic int clampi(input int v, input int lo, input int hi);
        return (v < lo) ? lo : ((v > hi) ? hi : v);
    endfunction

    task automatic model_reset();
        m_st = 0; m_x = SPAWN_X; m_y = SPAWN_Y; m_coll = 0;
        m_lives = LIVES; m_hit = 0; m_tl = 0;
    endtask

    task automatic model_step(input bit rst, input bit tick, input bit u, input bit d,
                              input bit l, input bit r, input bit st, input bit ak);
        int  nc;
        bit  hit, timeout;
        if (rst) begin
            model_reset();
            return;
        end
        timeout = 1'b0;
        if ((m_st == 1 || m_st == 2) && TIMER_ON && tick && m_tl > 0) begin
            m_tl--;
            timeout = (m_tl == 0);
        end
        case (m_st)
            0: begin
                model_reset();
                if (st) begin
                    m_st = 1;
                    m_tl = TIME_LIMIT;
                end
            end
            1: begin
                nc  = m_coll;
                hit = 1'b0;
                for (int i = 0; i < N_ITEMS; i++) begin
                    if (iabs(m_x - int'(item_x[i*CW +: CW])) <= ITEM_TOL &&
                        iabs(m_y - int'(item_y[i*CW +: CW])) <= ITEM_TOL)
                        nc |= (1 << i);
                end
                for (int t = 0; t < N_TRAPS; t++) begin
                    if (m_x - HALF <= int'(trap_x1[t*CW +: CW]) && m_x + HALF >= int'(trap_x0[t*CW +: CW]) &&
                        m_y - HALF <= int'(trap_y1[t*CW +: CW]) && m_y + HALF >= int'(trap_y0[t*CW +: CW]))
                        hit = 1'b1;
                end
                m_coll = nc;
                if (nc == (1 << N_ITEMS) - 1) m_st = 4;
                else if (timeout) m_st = 3;
                else if (hit) begin
                    if (m_lives == 1) begin
                        m_lives = 0; m_st = 3;
                    end else begin
                        m_lives--; m_x = SPAWN_X; m_y = SPAWN_Y; m_hit = HIT_TICKS; m_st = 2;
                    end
                end else if (tick) begin
                    m_x = clampi(m_x + STEP * (int'(r) - int'(l)), X_MIN, X_MAX);
                    m_y = clampi(m_y + STEP * (int'(d) - int'(u)), Y_MIN, Y_MAX);
                end
            end
            2: begin
                if (timeout) m_st = 3;
                else if (m_hit == 0) m_st = 1;
                else if (tick) m_hit--;
            end
            default: begin
                if (ak) model_reset();
            end
        endcase
    endtask

    // Drive one cycle of inputs at the falling edge and queue the expectation.
    task automatic cyc(input bit rst, input bit tick, input bit u, input bit d,
                       input bit l, input bit r, input bit st, input bit ak);
        exp_t e;
        @(negedge clk);
        reset = rst; move_tick = tick;
        btn_up = u; btn_down = d; btn_left = l; btn_right = r;
        start = st; ack = ak;
        model_step(rst, tick, u, d, l, r, st, ak);
        e.st = m_st; e.x = m_x; e.y = m_y; e.coll = m_coll;
        e.score = $countones(m_coll); e.lives = m_lives; e.tl = m_tl;
        sb_q.push_back(e);
    endtask

    // Layout changes are made only right after a reset cycle.
    task automatic set_item(input int i, input int x, input int y);
        item_x[i*CW +: CW] = CW'(x);
        item_y[i*CW +: CW] = CW'(y);
    endtask

    task automatic set_trap(input int t, input int x0, input int x1, input int y0, input int y1);
        trap_x0[t*CW +: CW] = CW'(x0); trap_x1[t*CW +: CW] = CW'(x1);
        trap_y0[t*CW +: CW] = CW'(y0); trap_y1[t*CW +: CW] = CW'(y1);
    endtask

    task automatic clear_layout();
        for (int i = 0; i < N_ITEMS; i++) set_item(i, 0, 0);
        for (int t = 0; t < N_TRAPS; t++) set_trap(t, 0, 0, 0, 0);
    endtask

    // Hand-derived absolute check of the state right after the last cyc().
    task automatic dir_check(input string name, input int st, input int x, input int y,
                             input int lv, input int sc);
        @(posedge clk);
        #2;
        chk({name, ".state"}, int'(state), st);
        chk({name, ".x"}, int'(player_x), x);
        chk({name, ".y"}, int'(player_y), y);
        chk({name, ".lives"}, int'(lives), lv);
        chk({name, ".score"}, int'(score), sc);
    endtask

    // Monitor: compare every output against the queued expectation.
    initial begin : monitor
        exp_t e;
        forever begin
            @(posedge clk);
            #1;
            if (sb_q.size() != 0) begin
                e = sb_q.pop_front();
                chk("sb.state", int'(state), e.st);
                chk("sb.player_x", int'(player_x), e.x);
                chk("sb.player_y", int'(player_y), e.y);
                chk("sb.collected", int'(collected), e.coll);
                chk("sb.score", int'(score), e.score);
                chk("sb.lives", int'(lives), e.lives);
                chk("sb.time_left", int'(time_left), e.tl);
            end
        end
    end

    // Directed scenarios followed by randomized games.
    initial begin : driver
        int x0, y0;
        // Reset and start
        cyc(1, 0, 0, 0, 0, 0, 0, 0);
        clear_layout();
        dir_check("reset", 0, 320, 70, 3, 0);
        cyc(0, 0, 0, 0, 0, 0, 1, 0);
        dir_check("start", 1, 320, 70, 3, 0);
        // Right saturation, up+down cancel, upper clamp
        repeat (100) cyc(0, 1, 0, 0, 0, 1, 0, 0);
        dir_check("x_sat", 1, 560, 70, 3, 0);
        repeat (5) cyc(0, 1, 1, 1, 0, 0, 0, 0);
        dir_check("ud_cancel", 1, 560, 70, 3, 0);
        repeat (5) cyc(0, 1, 1, 0, 0, 0, 0, 0);
        dir_check("y_sat", 1, 560, 60, 3, 0);

        // Item pickup is sticky
        cyc(1, 0, 0, 0, 0, 0, 0, 0);
        clear_layout();
        set_item(0, 324, 70);
        cyc(0, 0, 0, 0, 0, 0, 1, 0);
        dir_check("item_start", 1, 320, 70, 3, 0);
        cyc(0, 1, 0, 0, 0, 1, 0, 0);
        dir_check("item_take", 1, 324, 70, 3, 1);
        repeat (10) cyc(0, 1, 0, 0, 1, 0, 0, 0);
        dir_check("item_sticky", 1, 284, 70, 3, 1);

        // Walk left into a trap, invulnerable window, back to play
        cyc(1, 0, 0, 0, 0, 0, 0, 0);
        clear_layout();
        set_trap(0, 200, 260, 50, 70);
        cyc(0, 0, 0, 0, 0, 0, 1, 0);
        repeat (13) cyc(0, 1, 0, 0, 1, 0, 0, 0);
        dir_check("trap_edge", 1, 268, 70, 3, 0);
        cyc(0, 0, 0, 0, 1, 0, 0, 0);
        dir_check("trap_hit", 2, 320, 70, 2, 0);
        repeat (8) cyc(0, 1, 0, 0, 1, 0, 0, 0);
        dir_check("hit_hold", 2, 320, 70, 2, 0);
        cyc(0, 0, 0, 0, 0, 0, 0, 0);
        dir_check("hit_done", 1, 320, 70, 2, 0);

        // Trap on spawn drains all lives, ack returns to idle
        cyc(1, 0, 0, 0, 0, 0, 0, 0);
        clear_layout();
        set_trap(0, 310, 330, 60, 80);
        cyc(0, 0, 0, 0, 0, 0, 1, 0);
        repeat (25) cyc(0, 1, 0, 0, 0, 0, 0, 0);
        dir_check("drain_lose", 3, 320, 70, 0, 0);
        cyc(0, 0, 0, 0, 0, 0, 0, 1);
        dir_check("lose_ack", 0, 320, 70, 3, 0);

        // Final item together with a trap overlap wins
        cyc(1, 0, 0, 0, 0, 0, 0, 0);
        clear_layout();
        for (int i = 0; i < 3; i++) set_item(i, 320, 70);
        set_item(3, 340, 70);
        set_trap(0, 345, 350, 60, 80);
        cyc(0, 0, 0, 0, 0, 0, 1, 0);
        repeat (4) cyc(0, 1, 0, 0, 0, 1, 0, 0);
        dir_check("win_approach", 1, 336, 70, 3, 3);
        cyc(0, 0, 0, 0, 0, 0, 0, 0);
        dir_check("win", 4, 336, 70, 3, 4);
        cyc(0, 0, 0, 0, 0, 0, 1, 1);
        dir_check("win_ack_start", 0, 320, 70, 3, 0);
        cyc(0, 0, 0, 0, 0, 0, 1, 0);
        dir_check("restart", 1, 320, 70, 3, 0);

`ifdef MAZE_TIMER_EN
        // Idle in play until the countdown expires
        cyc(1, 0, 0, 0, 0, 0, 0, 0);
        clear_layout();
        cyc(0, 0, 0, 0, 0, 0, 1, 0);
        repeat (TIME_LIMIT) cyc(0, 1, 0, 0, 0, 0, 0, 0);
        dir_check("timeout", 3, 320, 70, 3, 0);
        chk("timeout.time_left", int'(time_left), 0);
`endif

        // Randomized games with items and traps clustered near spawn
        for (int g = 0; g < 8; g++) begin
            cyc(1, 0, 0, 0, 0, 0, 0, 0);
            for (int i = 0; i < N_ITEMS; i++)
                set_item(i, int'($urandom_range(345, 295)), int'($urandom_range(95, 60)));
            for (int t = 0; t < N_TRAPS; t++) begin
                x0 = int'($urandom_range(400, 230));
                y0 = int'($urandom_range(140, 40));
                set_trap(t, x0, x0 + int'($urandom_range(15, 0)), y0, y0 + int'($urandom_range(15, 0)));
            end
            for (int c = 0; c < 300; c++) begin
                cyc($urandom_range(199, 0) == 0, $urandom_range(1, 0) == 1,
                    $urandom_range(2, 0) == 0, $urandom_range(2, 0) == 0,
                    $urandom_range(2, 0) == 0, $urandom_range(2, 0) == 0,
                    $urandom_range(3, 0) == 0, $urandom_range(7, 0) == 0);
            end
        end

        @(posedge clk);
        #3;
        chk("scoreboard_drained", sb_q.size(), 0);
        $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
        $finish;
    end

endmodule
